// File: rtl/delay_pkg.sv
// Shared types and defaults for the delay-generator period monitor.
// Holds the monitor state encoding and the acceptance-window test.
package delay_pkg;

    typedef enum logic [1:0] {
        StSearch,
        StAcquire,
        StLocked,
        StFault
    } mon_state_e;

    localparam int unsigned DLY_N        = 20000;
    localparam int unsigned DLY_CBITS    = 15;
    localparam int unsigned DLY_TOL      = 2;
    localparam int unsigned DLY_LOCK_CNT = 4;

    // Lower bound written as g + tol >= n + 1 so nothing can underflow.
    function automatic logic in_window(input int unsigned g, input int unsigned n,
                                       input int unsigned tol);
        return (g + tol >= n + 1) && (g <= n + 1 + tol);
    endfunction

endpackage

// File: rtl/delay_gap_cnt.sv
// Saturating count of edges since the last pulse, with the window decode
// (good / early / late) of the current count.
module delay_gap_cnt
    import delay_pkg::*;
#(
    parameter int unsigned N     = DLY_N,
    parameter int unsigned CBITS = DLY_CBITS,
    parameter int unsigned TOL   = DLY_TOL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    output logic [CBITS-1:0] gap,
    output logic             good,
    output logic             early,
    output logic             late
);

    logic [CBITS-1:0] gap_q, gap_d;

    always_comb begin
        gap_d = gap_q;
        if (sig) begin
            gap_d = CBITS'(1);
        end else if (gap_q != '1) begin
            gap_d = gap_q + CBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

    assign gap   = gap_q;
    assign good  = in_window(32'(gap_q), N, TOL);
    assign early = (32'(gap_q) + TOL) < (N + 1);
    // A pulse landing on the last good count wins over the late condition.
    assign late  = !sig && (32'(gap_q) == N + 1 + TOL);

endmodule

// File: rtl/delay_monitor.sv
// Period watchdog for the delay generator tick: acquires lock after a run of
// in-window intervals, then flags early / missing pulses and counts faults.
module delay_monitor
    import delay_pkg::*;
#(
    parameter int unsigned N        = DLY_N,
    parameter int unsigned CBITS    = DLY_CBITS,
    parameter int unsigned TOL      = DLY_TOL,
    parameter int unsigned LOCK_CNT = DLY_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    output logic             locked,
    output logic             err_early,
    output logic             err_late,
    output logic             in_win,
    output logic [CBITS-1:0] period,
    output logic [7:0]       fault_cnt
);

    localparam logic [3:0] LockTarget = 4'(LOCK_CNT);

    mon_state_e       state_q, state_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [CBITS-1:0] period_q, period_d;
    logic [7:0]       fault_cnt_q, fault_cnt_d;
    logic             err_early_q, err_early_d;
    logic             err_late_q, err_late_d;

    logic [CBITS-1:0] gap;
    logic             gap_good, gap_early, gap_late;

    delay_gap_cnt #(
        .N     (N),
        .CBITS (CBITS),
        .TOL   (TOL)
    ) u_gap_cnt (
        .clk   (clk),
        .rst   (rst),
        .sig   (sig),
        .gap   (gap),
        .good  (gap_good),
        .early (gap_early),
        .late  (gap_late)
    );

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        period_d    = period_q;
        fault_cnt_d = fault_cnt_q;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;

        unique case (state_q)
            StSearch: begin
                if (sig) begin
                    state_d    = StAcquire;
                    good_cnt_d = '0;
                end
            end
            StAcquire: begin
                if (sig) begin
                    period_d = gap;
                    if (gap_good) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == LockTarget) begin
                            state_d = StLocked;
                        end
                    end else if (gap_early) begin
                        good_cnt_d  = '0;
                        err_early_d = 1'b1;
                    end
                end else if (gap_late) begin
                    state_d    = StSearch;
                    err_late_d = 1'b1;
                end
            end
            StLocked: begin
                if (sig) begin
                    period_d = gap;
                    if (gap_early) begin
                        err_early_d = 1'b1;
                        state_d     = StFault;
                        if (fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 8'd1;
                    end
                end else if (gap_late) begin
                    err_late_d = 1'b1;
                    state_d    = StFault;
                    if (fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 8'd1;
                end
            end
            StFault: begin
                // Pulse after a fault only re-establishes phase; it is not judged.
                if (sig) begin
                    state_d    = StAcquire;
                    good_cnt_d = '0;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSearch;
            good_cnt_q  <= '0;
            period_q    <= '0;
            fault_cnt_q <= '0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            period_q    <= period_d;
            fault_cnt_q <= fault_cnt_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
        end
    end

    assign locked    = (state_q == StLocked);
    assign err_early = err_early_q;
    assign err_late  = err_late_q;
    assign in_win    = (state_q != StSearch) && gap_good;
    assign period    = period_q;
    assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_delay_monitor.sv
// Bench for delay_monitor: directed scenarios plus randomized pulse trains,
// checked against a timestamp-based model of the monitor rules.
module tb_delay_monitor;

    localparam int unsigned N        = 20;
    localparam int unsigned CBITS    = 6;
    localparam int unsigned TOL      = 2;
    localparam int unsigned LOCK_CNT = 4;

    localparam int NOM  = N + 1;
    localparam int LO   = NOM - TOL;
    localparam int HI   = NOM + TOL;
    localparam int GMAX = (1 << CBITS) - 1;

    localparam int M_HUNT    = 0;
    localparam int M_TRAIN   = 1;
    localparam int M_HOLD    = 2;
    localparam int M_RECOVER = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig = 1'b0;
    logic             locked, err_early, err_late, in_win;
    logic [CBITS-1:0] period;
    logic [7:0]       fault_cnt;

    int errors = 0;
    int checks = 0;

    // Model: gap is derived from the timestamp of the last pulse or reset.
    int m_mode = M_HUNT, m_cnt = 0, m_period = 0, m_faults = 0;
    int m_ref = 0, m_base = 0, cyc = 0;
    bit m_early = 0, m_late = 0;

    delay_monitor #(
        .N        (N),
        .CBITS    (CBITS),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .locked    (locked),
        .err_early (err_early),
        .err_late  (err_late),
        .in_win    (in_win),
        .period    (period),
        .fault_cnt (fault_cnt)
    );

    always #5 clk = ~clk;

    function automatic int gap_at(input int e);
        int v;
        v = m_base + (e - m_ref - 1);
        if (v > GMAX) v = GMAX;
        return v;
    endfunction

    function automatic bit exp_in_win();
        int g;
        g = gap_at(cyc + 1);
        return (m_mode != M_HUNT) && (g >= LO) && (g <= HI);
    endfunction

    task automatic model(input bit s, input bit r);
        int e;
        int g;
        bit good;
        bit late_c;
        e = cyc + 1;
        g = gap_at(e);
        good = (g >= LO) && (g <= HI);
        late_c = !s && (g == HI);
        m_early = 0;
        m_late = 0;
        if (r) begin
            m_mode = M_HUNT; m_cnt = 0; m_period = 0; m_faults = 0;
            m_ref = e; m_base = 0;
        end else begin
            case (m_mode)
                M_HUNT: if (s) begin m_mode = M_TRAIN; m_cnt = 0; end
                M_TRAIN: begin
                    if (s) begin
                        m_period = g;
                        if (good) begin
                            m_cnt++;
                            if (m_cnt == int'(LOCK_CNT)) m_mode = M_HOLD;
                        end else begin
                            m_cnt = 0; m_early = 1;
                        end
                    end else if (late_c) begin
                        m_mode = M_HUNT; m_late = 1;
                    end
                end
                M_HOLD: begin
                    if (s) begin
                        m_period = g;
                        if (!good) begin
                            m_early = 1; m_mode = M_RECOVER;
                            if (m_faults < 255) m_faults++;
                        end
                    end else if (late_c) begin
                        m_late = 1; m_mode = M_RECOVER;
                        if (m_faults < 255) m_faults++;
                    end
                end
                M_RECOVER: if (s) begin m_mode = M_TRAIN; m_cnt = 0; end
                default: ;
            endcase
            if (s) begin m_ref = e; m_base = 1; end
        end
        cyc = e;
    endtask

    task automatic step(input bit s, input bit r);
        sig = s;
        rst = r;
        @(posedge clk);
        model(s, r);
        #1;
    endtask

    task automatic pulse_gap(input int k);
        for (int i = 0; i < k - 1; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
    endtask

    task automatic lock_up();
        step(1'b1, 1'b0);
        for (int i = 0; i < int'(LOCK_CNT); i++) pulse_gap(NOM);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
        checks++; if (err_early !== 1'b0) begin errors++; $display("FAIL reset_err_early: got %0b want 0", err_early); end
        checks++; if (err_late !== 1'b0) begin errors++; $display("FAIL reset_err_late: got %0b want 0", err_late); end
        checks++; if (in_win !== 1'b0) begin errors++; $display("FAIL reset_in_win: got %0b want 0", in_win); end
        checks++; if (period !== '0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
        checks++; if (fault_cnt !== 8'd0) begin errors++; $display("FAIL reset_fault_cnt: got %0d want 0", fault_cnt); end
    endtask

    task automatic test_lock();
        bit seen_err;
        seen_err = 0;
        do_reset();
        step(1'b1, 1'b0);
        checks++; if (period !== '0) begin errors++; $display("FAIL lock_ref_period: got %0d want 0", period); end
        for (int p = 1; p <= int'(LOCK_CNT); p++) begin
            for (int i = 0; i < NOM - 1; i++) begin
                step(1'b0, 1'b0);
                seen_err |= err_early | err_late;
            end
            step(1'b1, 1'b0);
            seen_err |= err_early | err_late;
            checks++;
            if (locked !== (p == int'(LOCK_CNT))) begin
                errors++; $display("FAIL lock_pulse%0d: locked got %0b want %0b", p, locked, p == int'(LOCK_CNT));
            end
        end
        checks++; if (period !== CBITS'(NOM)) begin errors++; $display("FAIL lock_period: got %0d want %0d", period, NOM); end
        checks++; if (seen_err !== 1'b0) begin errors++; $display("FAIL lock_no_errors: got flag %0b want 0", seen_err); end
    endtask

    task automatic test_window();
        do_reset();
        lock_up();
        pulse_gap(LO);
        checks++; if (locked !== 1'b1 || err_early !== 1'b0) begin errors++; $display("FAIL win_lo: locked=%0b err_early=%0b want 1/0", locked, err_early); end
        checks++; if (period !== CBITS'(LO)) begin errors++; $display("FAIL win_lo_period: got %0d want %0d", period, LO); end
        pulse_gap(HI);
        checks++; if (locked !== 1'b1 || err_late !== 1'b0) begin errors++; $display("FAIL win_hi: locked=%0b err_late=%0b want 1/0", locked, err_late); end
        checks++; if (period !== CBITS'(HI)) begin errors++; $display("FAIL win_hi_period: got %0d want %0d", period, HI); end
        pulse_gap(LO - 1);
        checks++; if (err_early !== 1'b1) begin errors++; $display("FAIL win_early_flag: got %0b want 1", err_early); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL win_early_locked: got %0b want 0", locked); end
        checks++; if (fault_cnt !== 8'd1) begin errors++; $display("FAIL win_early_faults: got %0d want 1", fault_cnt); end
        step(1'b0, 1'b0);
        checks++; if (err_early !== 1'b0) begin errors++; $display("FAIL win_early_pulse_len: got %0b want 0", err_early); end
    endtask

    task automatic test_missing();
        bit seen;
        do_reset();
        lock_up();
        for (int i = 0; i < HI - 1; i++) step(1'b0, 1'b0);
        checks++; if (err_late !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL miss_before: err_late=%0b locked=%0b want 0/1", err_late, locked); end
        step(1'b0, 1'b0);
        checks++; if (err_late !== 1'b1) begin errors++; $display("FAIL miss_late_flag: got %0b want 1", err_late); end
        checks++; if (locked !== 1'b0 || fault_cnt !== 8'd1) begin errors++; $display("FAIL miss_state: locked=%0b faults=%0d want 0/1", locked, fault_cnt); end
        seen = 0;
        for (int i = 0; i < 90; i++) begin
            step(1'b0, 1'b0);
            seen |= err_late | in_win;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL miss_fault_quiet: got %0b want 0", seen); end
        step(1'b1, 1'b0);
        for (int p = 1; p <= int'(LOCK_CNT); p++) begin
            pulse_gap(NOM);
            checks++;
            if (locked !== (p == int'(LOCK_CNT))) begin
                errors++; $display("FAIL miss_relock%0d: got %0b want %0b", p, locked, p == int'(LOCK_CNT));
            end
        end
        checks++; if (fault_cnt !== 8'd1) begin errors++; $display("FAIL miss_faults: got %0d want 1", fault_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        lock_up();
        pulse_gap(NOM);
        step(1'b1, 1'b0);
        checks++; if (err_early !== 1'b1) begin errors++; $display("FAIL b2b_early: got %0b want 1", err_early); end
        checks++; if (period !== CBITS'(1)) begin errors++; $display("FAIL b2b_period: got %0d want 1", period); end
        checks++; if (fault_cnt !== 8'd1 || locked !== 1'b0) begin errors++; $display("FAIL b2b_state: faults=%0d locked=%0b want 1/0", fault_cnt, locked); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 1'b0);
        pulse_gap(NOM);
        pulse_gap(NOM);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if ({locked, err_early, err_late, in_win} !== 4'b0 || period !== '0 || fault_cnt !== 8'd0) begin
            errors++; $display("FAIL rmid_outputs: l=%0b e=%0b t=%0b w=%0b p=%0d f=%0d want all 0",
                               locked, err_early, err_late, in_win, period, fault_cnt);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        checks++; if (period !== '0 || err_early !== 1'b0) begin errors++; $display("FAIL rmid_ref: period=%0d err_early=%0b want 0/0", period, err_early); end
        for (int p = 1; p <= int'(LOCK_CNT); p++) begin
            pulse_gap(NOM);
            checks++;
            if (locked !== (p == int'(LOCK_CNT))) begin
                errors++; $display("FAIL rmid_lock%0d: got %0b want %0b", p, locked, p == int'(LOCK_CNT));
            end
        end
        checks++; if (period !== CBITS'(NOM)) begin errors++; $display("FAIL rmid_period: got %0d want %0d", period, NOM); end
    endtask

    task automatic test_saturate();
        int want;
        do_reset();
        lock_up();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0);
            want = (i + 1 > 255) ? 255 : i + 1;
            checks++; if (fault_cnt !== 8'(want)) begin errors++; $display("FAIL sat_fault%0d: got %0d want %0d", i, fault_cnt, want); end
            pulse_gap(NOM);
            for (int p = 0; p < int'(LOCK_CNT); p++) pulse_gap(NOM);
        end
        checks++; if (fault_cnt !== 8'd255 || locked !== 1'b1) begin errors++; $display("FAIL sat_final: faults=%0d locked=%0b want 255/1", fault_cnt, locked); end
    endtask

    task automatic test_random();
        bit q[$];
        int kind, k;
        do_reset();
        for (int seg = 0; seg < 120; seg++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) k = NOM;
            else if (kind == 6) k = $urandom_range(LO, HI);
            else if (kind == 7) k = $urandom_range(1, LO - 1);
            else if (kind == 8) k = $urandom_range(HI + 1, 75);
            else k = $urandom_range(1, 40);
            for (int i = 0; i < k - 1; i++) q.push_back(1'b0);
            q.push_back(1'b1);
        end
        foreach (q[i]) begin
            step(q[i], 1'b0);
            checks++; if (locked !== (m_mode == M_HOLD)) begin errors++; $display("FAIL rnd_locked@%0d: got %0b want %0b", cyc, locked, m_mode == M_HOLD); end
            checks++; if (err_early !== m_early) begin errors++; $display("FAIL rnd_early@%0d: got %0b want %0b", cyc, err_early, m_early); end
            checks++; if (err_late !== m_late) begin errors++; $display("FAIL rnd_late@%0d: got %0b want %0b", cyc, err_late, m_late); end
            checks++; if (in_win !== exp_in_win()) begin errors++; $display("FAIL rnd_in_win@%0d: got %0b want %0b", cyc, in_win, exp_in_win()); end
            checks++; if (period !== CBITS'(m_period)) begin errors++; $display("FAIL rnd_period@%0d: got %0d want %0d", cyc, period, m_period); end
            checks++; if (fault_cnt !== 8'(m_faults)) begin errors++; $display("FAIL rnd_faults@%0d: got %0d want %0d", cyc, fault_cnt, m_faults); end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_window();
        test_missing();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
